// File: rtl/apb_pwm_pkg.sv
// Shared definitions for the APB PWM responder: register offsets, CTRL bit
// positions and the APB handshake state encoding.
package apb_pwm_pkg;

  // Byte offsets of the register bank (bits [1:0] of PADDR are ignored).
  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_PRESCALE = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h08;
  localparam logic [7:0] ADDR_DUTY0    = 8'h10;

  // CTRL register bit positions.
  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_INV = 1;

  typedef enum logic [0:0] {
    StIdle,
    StRdDone
  } apb_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty register plus registered comparator output.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   pwm_cnt_i : shared PWM counter
//   load_i    : copy duty_i into the shadow register this cycle
//   duty_i    : programmed duty value
//   en_i      : channel enable (output forced low when 0)
//   inv_i     : output polarity invert
//   pwm_o     : registered PWM output
module pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                load_i,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic                en_i,
  input  logic                inv_i,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] duty_sh_d, duty_sh_q;
  logic                pwm_d, pwm_q;

  always_comb begin
    duty_sh_d = load_i ? duty_i : duty_sh_q;
    // Compare against the shadow, never the live register, so a mid-period
    // write cannot shorten or stretch the current pulse.
    pwm_d     = en_i & ((pwm_cnt_i < duty_sh_q) ^ inv_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_sh_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/apb_pwm_responder.sv
// APB3 responder with an N_CH-channel PWM engine.
//   io_systemClk   : system clock, rising edge
//   io_systemReset : synchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : APB request
//   PRDATA/PREADY/PSLVERROR          : APB response (writes 0 wait, reads 1 wait)
//   o_pwm          : registered PWM outputs
// Registers: CTRL (EN, INV), PRESCALE[15:0], STATUS (period count, EN echo),
// DUTY[i]. Unmapped accesses and STATUS writes return PSLVERROR.
module apb_pwm_responder
  import apb_pwm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned N_CH       = 8,
  parameter int unsigned PWM_BITS   = 8
) (
  input  logic                  io_systemClk,
  input  logic                  io_systemReset,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERROR,
  output logic [N_CH-1:0]       o_pwm
);

  apb_state_e          state_d, state_q;
  logic [31:0]         rdata_d, rdata_q;
  logic                rerr_d, rerr_q;
  logic                ctrl_en_d, ctrl_en_q;
  logic                ctrl_inv_d, ctrl_inv_q;
  logic [15:0]         prescale_d, prescale_q;
  logic [PWM_BITS-1:0] duty_d [N_CH];
  logic [PWM_BITS-1:0] duty_q [N_CH];
  logic [15:0]         pre_cnt_d, pre_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_d, pwm_cnt_q;
  logic [15:0]         period_d, period_q;

  logic [ADDR_WIDTH-1:0] addr_w;
  logic                  sel_ctrl, sel_pre, sel_stat, mapped;
  logic [N_CH-1:0]       sel_duty;
  logic [31:0]           rd_mux;
  logic                  wr_fire, rd_fire, wr_err, wr_ok;
  logic                  tick, period_wrap, load;

  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

  // Address decode on the word address; upper address bits must be zero.
  assign addr_w = {PADDR[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    sel_ctrl = (addr_w == ADDR_WIDTH'(ADDR_CTRL));
    sel_pre  = (addr_w == ADDR_WIDTH'(ADDR_PRESCALE));
    sel_stat = (addr_w == ADDR_WIDTH'(ADDR_STATUS));
    for (int i = 0; i < N_CH; i++) begin
      sel_duty[i] = (addr_w == ADDR_WIDTH'(int'(ADDR_DUTY0) + 4 * i));
    end
    mapped = sel_ctrl | sel_pre | sel_stat | (|sel_duty);
  end

  always_comb begin
    rd_mux = '0;
    if (sel_ctrl) begin
      rd_mux[CTRL_EN]  = ctrl_en_q;
      rd_mux[CTRL_INV] = ctrl_inv_q;
    end
    if (sel_pre)  rd_mux[15:0] = prescale_q;
    if (sel_stat) rd_mux[16:0] = {ctrl_en_q, period_q};
    for (int i = 0; i < N_CH; i++) begin
      if (sel_duty[i]) rd_mux[PWM_BITS-1:0] = duty_q[i];
    end
  end

  // APB handshake.
  always_comb begin
    wr_fire = (state_q == StIdle) & PSEL & PENABLE & PWRITE;
    rd_fire = (state_q == StIdle) & PSEL & PENABLE & ~PWRITE;
    wr_err  = ~mapped | sel_stat;
    wr_ok   = wr_fire & ~wr_err;

    state_d = state_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      StIdle: begin
        if (rd_fire) begin
          state_d = StRdDone;
          rdata_d = rd_mux;
          rerr_d  = ~mapped;
        end
      end
      StRdDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    PREADY    = wr_fire | (state_q == StRdDone);
    PSLVERROR = wr_fire ? wr_err : ((state_q == StRdDone) & rerr_q);
    PRDATA    = (state_q == StRdDone) ? rdata_q : '0;
  end

  // Register bank writes.
  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    ctrl_inv_d = ctrl_inv_q;
    prescale_d = prescale_q;
    duty_d     = duty_q;
    if (wr_ok) begin
      if (sel_ctrl) begin
        ctrl_en_d  = PWDATA[CTRL_EN];
        ctrl_inv_d = PWDATA[CTRL_INV];
      end
      if (sel_pre) prescale_d = PWDATA[15:0];
      for (int i = 0; i < N_CH; i++) begin
        if (sel_duty[i]) duty_d[i] = PWDATA[PWM_BITS-1:0];
      end
    end
  end

  // Prescaler, PWM counter and period counter.
  always_comb begin
    tick        = 1'b0;
    period_wrap = 1'b0;
    pre_cnt_d   = '0;
    pwm_cnt_d   = '0;
    period_d    = '0;
    if (ctrl_en_q) begin
      // >= rather than == so a PRESCALE write below the running count wraps
      // on the next cycle instead of running through 0xFFFF.
      tick        = (pre_cnt_q >= prescale_q);
      pre_cnt_d   = tick ? '0 : pre_cnt_q + 16'd1;
      pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
      period_wrap = tick & (pwm_cnt_q == '1);
      period_d    = period_wrap ? period_q + 16'd1 : period_q;
    end
    // Shadows track DUTY continuously while disabled.
    load = ~ctrl_en_q | period_wrap;
  end

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      state_q    <= StIdle;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
      ctrl_en_q  <= 1'b0;
      ctrl_inv_q <= 1'b0;
      prescale_q <= '0;
      duty_q     <= '{default: '0};
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      period_q   <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      rerr_q     <= rerr_d;
      ctrl_en_q  <= ctrl_en_d;
      ctrl_inv_q <= ctrl_inv_d;
      prescale_q <= prescale_d;
      duty_q     <= duty_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      period_q   <= period_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk_i    (io_systemClk),
      .rst_i    (io_systemReset),
      .pwm_cnt_i(pwm_cnt_q),
      .load_i   (load),
      .duty_i   (duty_q[g]),
      .en_i     (ctrl_en_q),
      .inv_i    (ctrl_inv_q),
      .pwm_o    (o_pwm[g])
    );
  end

endmodule

// File: tb/tb_apb_pwm_responder.sv
module tb_apb_pwm_responder;

  localparam int unsigned AW  = 16;
  localparam int unsigned NCH = 8;
  localparam int unsigned PB  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;
  logic          pready, pslverror;
  logic [NCH-1:0] o_pwm;

  apb_pwm_responder #(
    .ADDR_WIDTH(AW),
    .N_CH      (NCH),
    .PWM_BITS  (PB)
  ) dut (
    .io_systemClk  (clk),
    .io_systemReset(rst),
    .PSEL          (psel),
    .PENABLE       (penable),
    .PWRITE        (pwrite),
    .PADDR         (paddr),
    .PWDATA        (pwdata),
    .PRDATA        (prdata),
    .PREADY        (pready),
    .PSLVERROR     (pslverror),
    .o_pwm         (o_pwm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // High-count accumulators over a measurement window.
  logic acc_on = 1'b0;
  int   acc_n;
  int   hi [NCH];

  // Reference model of the programmer-visible state.
  logic       m_en, m_inv;
  logic [15:0] m_pre;
  logic [7:0] m_duty [NCH];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_en = 1'b0; m_inv = 1'b0; m_pre = '0;
    for (int i = 0; i < NCH; i++) m_duty[i] = '0;
  endtask

  // kind: 0 CTRL, 1 PRESCALE, 2 STATUS, 3 DUTY, 4 unmapped
  task automatic decode(input logic [15:0] addr, output int kind, output int ch);
    int off;
    off  = int'({addr[15:2], 2'b00});
    ch   = 0;
    kind = 4;
    if (off == 0) kind = 0;
    else if (off == 4) kind = 1;
    else if (off == 8) kind = 2;
    else if (off >= 16 && off < 16 + 4 * NCH) begin
      kind = 3;
      ch   = (off - 16) / 4;
    end
  endtask

  // Every cycle advance goes through here, so each cycle is sampled once.
  task automatic next_cyc();
    if (acc_on) begin
      for (int i = 0; i < NCH; i++) hi[i] += o_pwm[i] ? 1 : 0;
      acc_n++;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic apb(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int waits);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    next_cyc();
    penable = 1'b1;
    #1;
    waits = 0;
    while (pready !== 1'b1 && waits < 8) begin
      if (waits == 0) check("prdata_while_wait", prdata, 32'd0);
      next_cyc();
      waits++;
    end
    rdata = prdata;
    err   = pslverror;
    check(wr ? "wr_latency" : "rd_latency", 32'(waits), wr ? 32'd0 : 32'd1);
    next_cyc();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_wr(input logic [15:0] addr, input logic [31:0] d, input string tag);
    logic [31:0] rd;
    logic        e, exp_err;
    int          w, k, ch;
    decode(addr, k, ch);
    exp_err = (k == 2 || k == 4);
    apb(1'b1, addr, d, rd, e, w);
    check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    check({tag, "_prdata"}, rd, 32'd0);
    if (!exp_err) begin
      case (k)
        0:       begin m_en = d[0]; m_inv = d[1]; end
        1:       m_pre = d[15:0];
        3:       m_duty[ch] = d[7:0];
        default: ;
      endcase
    end
  endtask

  task automatic do_rd(input logic [15:0] addr, input string tag);
    logic [31:0] rd, exp;
    logic        e, exp_err;
    int          w, k, ch;
    decode(addr, k, ch);
    exp_err = (k == 4);
    apb(1'b0, addr, 32'd0, rd, e, w);
    check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    exp = 32'd0;
    case (k)
      0:       exp = {30'b0, m_inv, m_en};
      1:       exp = {16'b0, m_pre};
      2:       exp = {15'b0, m_en, 16'h0};
      3:       exp = {24'b0, m_duty[ch]};
      default: ;
    endcase
    if (k == 2 && m_en) check({tag, "_en_echo"}, rd & 32'h0001_0000, 32'h0001_0000);
    else if (!exp_err) check({tag, "_data"}, rd, exp);
  endtask

  // Over a whole PWM period of cycles, a channel is high duty*mult cycles
  // (inverted: (256-duty)*mult), where mult is cycles per PWM step.
  task automatic measure(input int ncyc, input int mult, input string tag);
    int e;
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    acc_n  = 0;
    acc_on = 1'b1;
    while (acc_n < ncyc) next_cyc();
    acc_on = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      e = m_inv ? (256 - int'(m_duty[i])) * mult : int'(m_duty[i]) * mult;
      if (!m_en) e = 0;
      check($sformatf("%s_ch%0d", tag, i), 32'(hi[i]), 32'(e));
    end
  endtask

  initial begin
    int          r, off, found, p;
    logic [15:0] a;
    logic [31:0] d;
    logic        prev;
    logic [7:0]  old0;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    model_clear();
    @(negedge clk);
    #1;

    // Reset
    next_cyc();
    next_cyc();
    rst = 1'b0;
    #1;
    check("rst_pready", {31'b0, pready}, 32'd0);
    check("rst_pslverror", {31'b0, pslverror}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pwm", 32'(o_pwm), 32'd0);
    do_rd(16'h0000, "rst_ctrl");
    do_rd(16'h0004, "rst_pre");
    do_rd(16'h0008, "rst_status");
    for (int i = 0; i < NCH; i++) do_rd(16'(16 + 4 * i), "rst_duty");

    // Write / read-back and errors
    do_wr(16'h0004, 32'h0000_1234, "wr_pre");
    do_rd(16'h0004, "rd_pre");
    do_wr(16'h0008, 32'hFFFF_FFFF, "wr_status");
    do_rd(16'h0008, "rd_status");
    do_rd(16'h0040, "rd_unmapped");
    do_wr(16'h0040, 32'hFFFF_FFFF, "wr_unmapped");

    // Random back-to-back register traffic with EN held off
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 15));
      case (r)
        0, 1, 2, 3: off = r * 4;
        12:         off = 16'h30;
        13:         off = 16'h3C;
        14:         off = 16'h100;
        15:         off = 16'h8010;
        default:    off = 16 + (r - 4) * 4;
      endcase
      a = 16'(off) | 16'($urandom_range(0, 3));
      d = $urandom;
      if (off == 0) d[0] = 1'b0;
      if ($urandom_range(0, 1) == 1) do_wr(a, d, "rnd_wr");
      else do_rd(a, "rnd_rd");
    end

    // PWM duty
    do_wr(16'h0004, 32'd0, "cfg_pre");
    do_wr(16'h0010, 32'd64, "cfg_d0");
    do_wr(16'h0014, 32'd0, "cfg_d1");
    do_wr(16'h002C, 32'd255, "cfg_d7");
    for (int i = 2; i < 7; i++) do_wr(16'(16 + 4 * i), $urandom, "cfg_dn");
    do_wr(16'h0000, 32'd1, "cfg_en");
    repeat (4) next_cyc();
    measure(256, 1, "duty");
    do_rd(16'h0008, "status_on");

    // Glitch-free duty update: align to the rising edge of ch0 (period start)
    prev  = o_pwm[0];
    found = 0;
    for (int n = 0; n < 600; n++) begin
      next_cyc();
      if (!prev && o_pwm[0]) begin
        found = 1;
        break;
      end
      prev = o_pwm[0];
    end
    check("period_start_found", 32'(found), 32'd1);
    old0 = m_duty[0];
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    acc_n  = 0;
    acc_on = 1'b1;
    repeat (10) next_cyc();
    do_wr(16'h0010, 32'd200, "wr_d0_mid");
    while (acc_n < 256) next_cyc();
    acc_on = 1'b0;
    check("glitch_cur_period", 32'(hi[0]), 32'(old0));
    measure(256, 1, "glitch_next");

    // Invert, then disable with and without INV
    do_wr(16'h0000, 32'd3, "cfg_inv");
    repeat (4) next_cyc();
    measure(256, 1, "inv");
    do_wr(16'h0000, 32'd0, "cfg_off");
    repeat (3) next_cyc();
    check("off_pwm", 32'(o_pwm), 32'd0);
    do_rd(16'h0008, "off_status");
    do_wr(16'h0000, 32'd2, "cfg_off_inv");
    repeat (3) next_cyc();
    measure(256, 1, "off_inv");
    do_rd(16'h0008, "off_inv_status");

    // Random prescale and duties
    p = int'($urandom_range(1, 3));
    do_wr(16'h0004, 32'(p), "rnd_pre");
    for (int i = 0; i < NCH; i++) do_wr(16'(16 + 4 * i), $urandom, "rnd_duty");
    do_wr(16'h0000, {30'b0, 1'($urandom_range(0, 1)), 1'b1}, "rnd_ctrl");
    repeat (4) next_cyc();
    measure(256 * (p + 1), p + 1, "presc");

    // Reset in the read access cycle
    do_wr(16'h0004, 32'h55, "pre_before_rst");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0004;
    next_cyc();
    penable = 1'b1;
    rst     = 1'b1;
    #1;
    check("midrst_access_pready", {31'b0, pready}, 32'd0);
    next_cyc();
    check("midrst_after_pready", {31'b0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    next_cyc();
    rst = 1'b0;
    model_clear();
    check("midrst_pwm", 32'(o_pwm), 32'd0);
    do_rd(16'h0004, "post_rst_pre");
    do_rd(16'h0000, "post_rst_ctrl");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
